// File: rtl/mul_sched_pkg.sv
// Shared types and constants for the nibble multiply sequencer.
// Optional MUL_SCHED_STATS_EN adds a completed-result counter to the top.
package mul_sched_pkg;

    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned NIB     = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    // sh is wide enough for the largest shift, 4*(2N-2) = 56 at WIDTH=32
    typedef struct packed {
        logic       v;
        logic [7:0] sh;
    } tag_t;

endpackage

// File: rtl/mul_sched_acc.sv
// Tag pipe aligned with the external multiplier latency, plus the
// shift-add accumulator that folds each returning partial product in.
module mul_sched_acc
    import mul_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LAT   = MUL_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  tag_t               tag_in,
    input  logic [7:0]         mul_p,
    output logic [2*WIDTH-1:0] acc
);

    tag_t               pipe [LAT];
    logic [2*WIDTH-1:0] part;

    always_comb begin
        part = (2*WIDTH)'(mul_p) << pipe[LAT-1].sh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < LAT; k++) begin
                pipe[k] <= '0;
            end
            acc <= '0;
        end else begin
            pipe[0] <= tag_in;
            for (int unsigned k = 1; k < LAT; k++) begin
                pipe[k] <= pipe[k-1];
            end
            if (clr) begin
                acc <= '0;
            end else if (pipe[LAT-1].v) begin
                acc <= acc + part;
            end
        end
    end

endmodule

// File: rtl/mul_nibble_sched.sv
// WIDTH x WIDTH multiply sequenced over an external 4x4 pipelined multiplier.
// Define MUL_SCHED_STATS_EN to add the stat_ops completed-result counter port.
module mul_nibble_sched #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [3:0]         mul_a,
    output logic [3:0]         mul_b,
    output logic               mul_ena,
    output logic               mul_rst_n,
    input  logic [7:0]         mul_p
`ifdef MUL_SCHED_STATS_EN
    ,
    output logic [31:0]        stat_ops
`endif
);

    import mul_sched_pkg::*;

    localparam int unsigned N = WIDTH / NIB;

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [3:0]         i;
    logic [3:0]         j;
    logic [3:0]         ni;
    logic [3:0]         nj;
    logic [3:0]         dcnt;
    logic               accept;
    logic               last_pair;
    tag_t               tag;
    tag_t               tag_n;
    logic [2*WIDTH-1:0] acc;

    assign mul_rst_n = ~rst;

    // i/j name the pair currently on mul_a/mul_b; ni/nj the one to present next
    always_comb begin
        accept     = (state == IDLE) && in_valid;
        last_pair  = (i == 4'(N-1)) && (j == 4'(N-1));
        nj         = (j == 4'(N-1)) ? '0 : j + 4'd1;
        ni         = (j == 4'(N-1)) ? i + 4'd1 : i;
        tag_n.v    = 1'b1;
        tag_n.sh   = 8'({ni, 2'b00}) + 8'({nj, 2'b00});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_p     <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_ena   <= 1'b0;
            i         <= '0;
            j         <= '0;
            dcnt      <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            tag       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= in_a;
                        b_reg    <= in_b;
                        i        <= '0;
                        j        <= '0;
                        mul_a    <= in_a[3:0];
                        mul_b    <= in_b[3:0];
                        mul_ena  <= 1'b1;
                        tag      <= '{v: 1'b1, sh: 8'd0};
                        in_ready <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (last_pair) begin
                        mul_a <= '0;
                        mul_b <= '0;
                        tag   <= '0;
                        dcnt  <= '0;
                        state <= DRAIN;
                    end else begin
                        i     <= ni;
                        j     <= nj;
                        mul_a <= 4'(a_reg >> {ni, 2'b00});
                        mul_b <= 4'(b_reg >> {nj, 2'b00});
                        tag   <= tag_n;
                    end
                end
                // one extra cycle past MUL_LAT lets the final add settle into acc
                DRAIN: begin
                    if (dcnt == 4'(MUL_LAT)) begin
                        out_valid <= 1'b1;
                        out_p     <= acc;
                        mul_ena   <= 1'b0;
                        state     <= DONE;
                    end else begin
                        dcnt <= dcnt + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mul_sched_acc #(
        .WIDTH (WIDTH),
        .LAT   (MUL_LAT)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .tag_in (tag),
        .mul_p  (mul_p),
        .acc    (acc)
    );

`ifdef MUL_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops <= '0;
        end else if (out_valid && out_ready && (stat_ops != '1)) begin
            stat_ops <= stat_ops + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mul_nibble_sched.sv
// Scoreboard bench: WIDTH=8 and WIDTH=32 sequencers, each driving a model
// of the 2-stage 4x4 multiplier.
module tb_mul_nibble_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] p;
        int unsigned cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q32[$];

    // ---------------- WIDTH=8 instance ----------------
    logic        rst8 = 1'b1, iv8 = 1'b0, or8 = 1'b1;
    logic        ir8, ov8, me8, mrn8;
    logic [7:0]  a8 = '0, b8 = '0, mp8, s1_8, s2_8;
    logic [15:0] p8;
    logic [3:0]  ma8, mb8;
`ifdef MUL_SCHED_STATS_EN
    logic [31:0] st8;
`endif

    mul_nibble_sched #(.WIDTH(8), .MUL_LAT(2)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8),
        .in_a(a8), .in_b(b8), .out_valid(ov8), .out_ready(or8), .out_p(p8),
        .mul_a(ma8), .mul_b(mb8), .mul_ena(me8), .mul_rst_n(mrn8), .mul_p(mp8)
`ifdef MUL_SCHED_STATS_EN
        , .stat_ops(st8)
`endif
    );

    always @(posedge clk) begin
        if (!mrn8 || !me8) begin
            s1_8 <= '0; s2_8 <= '0;
        end else begin
            s1_8 <= ma8 * mb8; s2_8 <= s1_8;
        end
    end
    assign mp8 = s2_8;

    // ---------------- WIDTH=32 instance ----------------
    logic        rst32 = 1'b1, iv32 = 1'b0, or32 = 1'b1;
    logic        ir32, ov32, me32, mrn32;
    logic [31:0] a32 = '0, b32 = '0;
    logic [7:0]  mp32, s1_32, s2_32;
    logic [63:0] p32;
    logic [3:0]  ma32, mb32;
`ifdef MUL_SCHED_STATS_EN
    logic [31:0] st32;
`endif

    mul_nibble_sched #(.WIDTH(32), .MUL_LAT(2)) dut32 (
        .clk(clk), .rst(rst32), .in_valid(iv32), .in_ready(ir32),
        .in_a(a32), .in_b(b32), .out_valid(ov32), .out_ready(or32), .out_p(p32),
        .mul_a(ma32), .mul_b(mb32), .mul_ena(me32), .mul_rst_n(mrn32), .mul_p(mp32)
`ifdef MUL_SCHED_STATS_EN
        , .stat_ops(st32)
`endif
    );

    always @(posedge clk) begin
        if (!mrn32 || !me32) begin
            s1_32 <= '0; s2_32 <= '0;
        end else begin
            s1_32 <= ma32 * mb32; s2_32 <= s1_32;
        end
    end
    assign mp32 = s2_32;

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic        ov8_prev = 1'b0, ov32_prev = 1'b0;
    int unsigned rise8 = 0, rise32 = 0;
    int unsigned done32 = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst8) ov8_prev = 1'b0;
        if (ov8 && !ov8_prev) rise8 = cyc;
        ov8_prev = ov8;
        if (ov8 && or8) begin
            if (q8.size() == 0) begin
                fail_now("w8_unexpected_result");
            end else begin
                e = q8.pop_front();
                chk("w8_product", 64'(p8), e.p);
                chk("w8_latency", 64'(rise8 - e.cyc), 64'd7);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst32) begin
            ov32_prev = 1'b0;
            done32 = 0;
        end
        if (ov32 && !ov32_prev) rise32 = cyc;
        ov32_prev = ov32;
        if (ov32 && or32) begin
            done32++;
            if (q32.size() == 0) begin
                fail_now("w32_unexpected_result");
            end else begin
                e = q32.pop_front();
                chk("w32_product", p32, e.p);
                chk("w32_latency", 64'(rise32 - e.cyc), 64'd67);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e, input bit push);
        int unsigned n = 0;
        exp_t x;
        while (!ir8 && n < 500) begin step(); n++; end
        if (!ir8) begin fail_now("w8_in_ready_timeout"); return; end
        a8 = a; b8 = b; iv8 = 1'b1;
        if (push) begin x.p = 64'(e); x.cyc = cyc + 1; q8.push_back(x); end
        step();
        iv8 = 1'b0;
    endtask

    task automatic send32(input logic [31:0] a, input logic [31:0] b);
        int unsigned n = 0;
        exp_t x;
        while (!ir32 && n < 500) begin step(); n++; end
        if (!ir32) begin fail_now("w32_in_ready_timeout"); return; end
        a32 = a; b32 = b; iv32 = 1'b1;
        x.p = 64'(a) * 64'(b); x.cyc = cyc + 1; q32.push_back(x);
        step();
        iv32 = 1'b0;
    endtask

    task automatic seq8();
        int unsigned n;
        repeat (3) step();
        rst8 = 1'b0;
        step();
        chk("w8_rst_in_ready", 64'(ir8), 64'd1);
        chk("w8_rst_out_valid", 64'(ov8), 64'd0);
        chk("w8_rst_out_p", 64'(p8), 64'd0);
        chk("w8_rst_mul_a", 64'(ma8), 64'd0);
        chk("w8_rst_mul_b", 64'(mb8), 64'd0);
        chk("w8_rst_mul_ena", 64'(me8), 64'd0);

        send8(8'hFF, 8'hFF, 16'hFE01, 1'b1);
        send8(8'h00, 8'hA5, 16'h0000, 1'b1);
        send8(8'h0F, 8'h10, 16'h00F0, 1'b1);

        // busy-time request must be dropped
        send8(8'h21, 8'h02, 16'h0042, 1'b1);
        a8 = 8'h77; b8 = 8'h77; iv8 = 1'b1;
        repeat (3) step();
        iv8 = 1'b0;

        // back-pressure hold
        n = 0;
        while (!ir8 && n < 200) begin step(); n++; end
        or8 = 1'b0;
        send8(8'h12, 8'h34, 16'h03A8, 1'b1);
        n = 0;
        while (!ov8 && n < 100) begin step(); n++; end
        if (!ov8) fail_now("w8_out_valid_timeout");
        for (int k = 0; k < 5; k++) begin
            chk("w8_hold_valid", 64'(ov8), 64'd1);
            chk("w8_hold_p", 64'(p8), 64'h03A8);
            chk("w8_hold_in_ready", 64'(ir8), 64'd0);
            step();
        end
        or8 = 1'b1;
        step();

        // abort mid-ISSUE
        send8(8'h55, 8'h66, 16'h0000, 1'b0);
        rst8 = 1'b1;
        step();
        rst8 = 1'b0;
        chk("w8_abort_in_ready", 64'(ir8), 64'd1);
        chk("w8_abort_out_valid", 64'(ov8), 64'd0);
        chk("w8_abort_mul_ena", 64'(me8), 64'd0);
        send8(8'h03, 8'h05, 16'h000F, 1'b1);
        send8(8'hA5, 8'h5A, 16'h3A02, 1'b1);

        n = 0;
        while (q8.size() != 0 && n < 500) begin step(); n++; end
        if (q8.size() != 0) fail_now("w8_drain_timeout");
        repeat (10) step();
    endtask

    task automatic seq32();
        int unsigned n;
        repeat (3) step();
        rst32 = 1'b0;
        step();
        send32(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send32(32'h0000_0001, 32'hFFFF_FFFF);
        send32(32'h0001_0000, 32'h0001_0000);
        send32(32'h0000_0000, 32'hDEAD_BEEF);
        for (int k = 0; k < 200; k++) begin
            send32($urandom, $urandom);
        end
        n = 0;
        while (q32.size() != 0 && n < 1000) begin step(); n++; end
        if (q32.size() != 0) fail_now("w32_drain_timeout");
        step();
`ifdef MUL_SCHED_STATS_EN
        chk("w32_stat_ops", 64'(st32), 64'(done32));
`endif
    endtask

    initial begin
        fork
            seq8();
            seq32();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
